// File: rtl/alu_srcb_stage_pkg.sv
// Shared definitions for the ALU operand-B select stage: source encodings,
// the PC increment constant and the elastic buffer occupancy states.
package alu_srcb_stage_pkg;

  // ALUSrcB encodings as seen by the control unit
  typedef enum logic [1:0] {
    SRCB_REG      = 2'd0,
    SRCB_FOUR     = 2'd1,
    SRCB_IMM      = 2'd2,
    SRCB_IMM_SHL2 = 2'd3
  } srcb_e;

  localparam int PC_INCR = 4;

  // Occupancy of the 2-entry elastic buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  function automatic logic sel_out_of_range(input int sel_val, input int num_in);
    return sel_val >= num_in;
  endfunction

endpackage

// File: rtl/alu_srcb_stage_skid.sv
// Generic 2-entry elastic buffer with synchronous flush. in_ready and out_valid
// are registered so neither side sees a combinational path from the other.
//
// state    | meaning
// ST_EMPTY | no entry held, out_valid low, head keeps last value
// ST_ONE   | head holds the entry on out_payload
// ST_FULL  | head on output, skid holds the next entry, in_ready low
module skid_buffer_2
  import alu_srcb_stage_pkg::*;
#(
  parameter int WIDTH_PAYLOAD = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH_PAYLOAD-1:0] in_payload,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH_PAYLOAD-1:0] out_payload
);

  skid_state_e              state_q;
  skid_state_e              state_nxt;
  logic [WIDTH_PAYLOAD-1:0] head_q;
  logic [WIDTH_PAYLOAD-1:0] skid_q;
  logic                     accept;
  logic                     pop;

  assign accept      = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign out_payload = head_q;

  always_comb begin
    state_nxt = state_q;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_nxt = ST_ONE;
        ST_ONE: begin
          if (accept && !pop)      state_nxt = ST_FULL;
          else if (!accept && pop) state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (pop) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      head_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      in_ready  <= (state_nxt != ST_FULL);
      out_valid <= (state_nxt != ST_EMPTY);
      // data registers are left alone on flush; only occupancy is cleared
      if (!flush) begin
        case (state_q)
          ST_EMPTY: if (accept) head_q <= in_payload;
          ST_ONE: begin
            if (accept && pop) head_q <= in_payload;
            else if (accept)   skid_q <= in_payload;
          end
          ST_FULL:  if (pop) head_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/alu_srcb_stage.sv
// Registered operand-B selector: picks a source or the PC increment constant
// and queues {sel_err, sel, data} through a 2-entry elastic buffer.
module alu_srcb_stage
  import alu_srcb_stage_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_IN    = 4,
  parameter int SEL_W     = 2,
  parameter int CONST_IDX = int'(SRCB_FOUR),
  parameter int CONST_VAL = PC_INCR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err
);

  localparam int PW = WIDTH + SEL_W + 1;

  logic [WIDTH-1:0] sel_data;
  logic             sel_bad;
  logic [PW-1:0]    payload_in;
  logic [PW-1:0]    payload_out;

  // constant index wins over its in_data slice; out-of-range selects give 0
  always_comb begin
    sel_data = '0;
    sel_bad  = 1'b0;
    if (int'(sel) == CONST_IDX) begin
      sel_data = WIDTH'(CONST_VAL);
    end else if (sel_out_of_range(int'(sel), NUM_IN)) begin
      sel_bad = 1'b1;
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (int'(sel) == k) sel_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign payload_in = {sel_bad, sel, sel_data};

  skid_buffer_2 #(
    .WIDTH_PAYLOAD(PW)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_payload (payload_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(payload_out)
  );

  assign {sel_err, out_sel, out_data} = payload_out;

endmodule

// File: tb/tb_alu_srcb_stage.sv
// Scoreboard bench for alu_srcb_stage: a 4-source and a 3-source instance share
// stimulus; expected {err, sel, data} entries are queued on accept and popped by a monitor.
module tb_alu_srcb_stage;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [1:0]   sel = '0;
  logic [127:0] in_data = '0;
  logic         out_ready = 1'b0;

  logic         in_ready4, out_valid4, sel_err4;
  logic [31:0]  out_data4;
  logic [1:0]   out_sel4;
  logic         in_ready3, out_valid3, sel_err3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;

  logic [34:0]  q4[$];
  logic [34:0]  q3[$];
  int           total = 0;
  int           bad = 0;
  int           pops4 = 0;

  localparam logic [127:0] DSET = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};

  always #5 clk = ~clk;

  alu_srcb_stage #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .CONST_IDX(1), .CONST_VAL(4)) u4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .sel(sel), .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_sel(out_sel4), .sel_err(sel_err4));

  alu_srcb_stage #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .CONST_IDX(1), .CONST_VAL(4)) u3 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
    .sel(sel), .in_data(in_data[95:0]), .out_valid(out_valid3), .out_ready(out_ready),
    .out_data(out_data3), .out_sel(out_sel3), .sel_err(sel_err3));

  // Reference: selector value 1 is the PC increment, below num_in picks a slice, else error
  function automatic logic [34:0] model(input int n, input logic [1:0] s, input logic [127:0] d);
    int k;
    k = int'(s);
    if (k == 1) return {1'b0, s, 32'd4};
    if (k < n)  return {1'b0, s, d[k*32 +: 32]};
    return {1'b1, s, 32'd0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [127:0] d,
                       input logic ordy, input logic fl);
    @(negedge clk);
    in_valid = v; sel = s; in_data = d; out_ready = ordy; flush = fl;
    if (fl) begin
      q4.delete();
      q3.delete();
    end else if (v && in_ready4) begin
      q4.push_back(model(4, s, d));
      q3.push_back(model(3, s, d));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q4.size() != 0 || q3.size() != 0); i++)
      drive(1'b0, 2'd0, '0, 1'b1, 1'b0);
    drive(1'b0, 2'd0, '0, 1'b1, 1'b0);
    chk("drain_q4", 64'(q4.size()), 64'd0);
    chk("drain_q3", 64'(q3.size()), 64'd0);
  endtask

  // Monitor: every pop must match the oldest queued expectation
  always @(posedge clk) begin
    if (!reset && !flush && out_ready) begin
      if (out_valid4) begin
        pops4++;
        if (q4.size() == 0) chk("unexpected_out4", 64'(out_data4), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("out4", 64'({sel_err4, out_sel4, out_data4}), 64'(q4.pop_front()));
      end
      if (out_valid3) begin
        if (q3.size() == 0) chk("unexpected_out3", 64'(out_data3), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("out3", 64'({sel_err3, out_sel3, out_data3}), 64'(q3.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL timeout: simulation did not finish at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int p0;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready4), 64'd0);
    chk("rst_in_ready3", 64'(in_ready3), 64'd0);
    chk("rst_out_valid", 64'(out_valid4), 64'd0);
    chk("rst_out_word", 64'({sel_err4, out_sel4, out_data4}), 64'd0);
    reset = 1'b0;
    #1 chk("rel_in_ready_before_clk", 64'(in_ready4), 64'd0);
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready4), 64'd1);

    // select all sources, one per cycle
    drive(1'b1, 2'd0, DSET, 1'b1, 1'b0);
    drive(1'b1, 2'd1, DSET, 1'b1, 1'b0);
    chk("latency_valid", 64'(out_valid4), 64'd1);
    chk("latency_data", 64'(out_data4), 64'h0000_AAAA);
    drive(1'b1, 2'd2, DSET, 1'b1, 1'b0);
    chk("const_sel1", 64'(out_data4), 64'd4);
    drive(1'b1, 2'd3, DSET, 1'b1, 1'b0);
    drain();
    chk("empty_valid", 64'(out_valid4), 64'd0);
    chk("empty_hold", 64'(out_data4), 64'h0000_DDDD);

    // backpressure
    drive(1'b1, 2'd0, DSET, 1'b0, 1'b0);
    drive(1'b1, 2'd2, DSET, 1'b0, 1'b0);
    drive(1'b0, 2'd0, DSET, 1'b0, 1'b0);
    chk("bp_full_in_ready", 64'(in_ready4), 64'd0);
    chk("bp_head", 64'(out_data4), 64'h0000_AAAA);
    drive(1'b0, 2'd0, DSET, 1'b1, 1'b0);
    drive(1'b0, 2'd0, DSET, 1'b1, 1'b0);
    chk("bp_in_ready_after_pop", 64'(in_ready4), 64'd1);
    drain();

    // full-rate stream
    p0 = pops4;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'(i % 4), {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
      if (i > 0) chk("stream_in_ready", 64'(in_ready4), 64'd1);
    end
    drain();
    chk("stream_count", 64'(pops4 - p0), 64'd8);

    // out-of-range select on the 3-source instance
    drive(1'b1, 2'd3, DSET, 1'b1, 1'b0);
    drive(1'b1, 2'd0, DSET, 1'b1, 1'b0);
    chk("bad_err", 64'(sel_err3), 64'd1);
    chk("bad_data", 64'(out_data3), 64'd0);
    chk("bad_sel", 64'(out_sel3), 64'd3);
    drive(1'b0, 2'd0, DSET, 1'b1, 1'b0);
    chk("bad_err_clear", 64'(sel_err3), 64'd0);
    chk("bad_next_data", 64'(out_data3), 64'h0000_AAAA);
    drain();

    // flush from FULL with a concurrent input
    drive(1'b1, 2'd0, DSET, 1'b0, 1'b0);
    drive(1'b1, 2'd2, DSET, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 128'h5555_5555_5555_5555_5555_5555_5555_5555, 1'b0, 1'b1);
    drive(1'b0, 2'd0, '0, 1'b1, 1'b0);
    chk("flush_valid4", 64'(out_valid4), 64'd0);
    chk("flush_valid3", 64'(out_valid3), 64'd0);
    chk("flush_in_ready", 64'(in_ready4), 64'd1);
    drain();

    // randomized traffic with occasional flush
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    drain();

    // reset in the middle of traffic
    drive(1'b1, 2'd0, DSET, 1'b0, 1'b0);
    drive(1'b1, 2'd2, DSET, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    q4.delete();
    q3.delete();
    #1;
    chk("midrst_valid", 64'(out_valid4), 64'd0);
    chk("midrst_word", 64'({sel_err4, out_sel4, out_data4}), 64'd0);
    chk("midrst_in_ready", 64'(in_ready4), 64'd0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_rel_in_ready", 64'(in_ready4), 64'd1);
    chk("midrst_rel_valid", 64'(out_valid4), 64'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
